pay_collector: RTL
==================

// Module: pay_collector
// PURPOSE
// - Payment stage downstream of the vending-machine keypad/selection logic and upstream of the display and Bgm blocks.
// - Armed by a start pulse carrying the total due. Debounces coin-switch inputs and accumulates the amount paid.
// - Runs a per-second countdown and decides success, timeout or cancel.
// - Returns change (success) or a refund (failure), with BCD digits ready for the seven-segment display.
// PARAMETERS
// - TICK_CYC      100_000_000  clk cycles per countdown second
// - TIMEOUT_S     30           seconds allowed to pay (1..31)
// - DEBOUNCE_CYC  1_000_000    cycles coin[1:0] must be stable before it is accepted
// PORTS
// - clk        in   1  system clock
// - rst        in   1  reset; asynchronous, active-high
// - start      in   1  one-cycle pulse: begin a payment session
// - cost       in   7  total due, 0..99; sampled on start
// - coin       in   2  coin switch level: 00 none, 01 = 1, 10 = 5, 11 = 10
// - cancel     in   1  one-cycle pulse: abort the session and refund
// - busy       out  1  session in progress (COLLECT or SETTLE)
// - paid       out  7  amount accumulated in this session
// - paid_one   out  4  BCD ones digit of paid
// - paid_ten   out  4  BCD tens digit of paid
// - chg_one    out  4  BCD ones digit of change/refund
// - chg_ten    out  4  BCD tens digit of change/refund
// - secs_left  out  5  countdown value shown to the user
// - done       out  1  one-cycle pulse at session end
// - success    out  1  level: last session completed paid >= cost
// - timed_out  out  1  level: last session ended by timeout
// BEHAVIOUR
// - Reset values (while rst is asserted): state IDLE; every output is 0; debounce and tick counters are 0.
// - FSM states: IDLE, COLLECT, SETTLE, FINISH.
//   - IDLE -> COLLECT on start.
//     - Latch cost. Clear paid and the change outputs.
//     - Clear success and timed_out. Load secs_left = TIMEOUT_S.
//     - Clear the tick counter.
//   - COLLECT -> SETTLE on the first cycle in which any of these holds: paid >= cost, cancel, or the timeout expires.
//   - SETTLE (1 cycle): compute the result.
//     - paid >= cost: change = paid - cost, success = 1.
//     - Otherwise: change = paid (full refund), and timed_out = 1 if the timeout caused the exit.
//   - SETTLE -> FINISH. FINISH asserts done for exactly 1 cycle, then returns to IDLE.
//   - Results stay held until the next start.
// - Latency: start to busy = 1 cycle. Qualifying condition in COLLECT to done = 2 cycles.
// - busy = 1 in COLLECT and SETTLE only.
// - start is ignored while not IDLE. cancel is ignored outside COLLECT.
// - cost = 0: session enters COLLECT, exits on the first COLLECT cycle, and reports success with change 0.
// - Countdown:
//   - The tick counter runs only in COLLECT. It wraps at TICK_CYC-1 and decrements secs_left.
//   - Timeout fires when secs_left would decrement from 1 to 0. secs_left then shows 0.
// - Coin debounce:
//   - A change of coin restarts the stability counter.
//   - A nonzero value stable for DEBOUNCE_CYC cycles is accepted once.
//   - coin must then read 00 stable for DEBOUNCE_CYC before another coin is accepted. A held switch counts once.
//   - Coins are accepted only in COLLECT. Coins present in other states are discarded, not queued.
// - Arithmetic:
//   - paid saturates at 99.
//   - BCD outputs are combinational splits of the registered values: ten = v/10, one = v%10, each digit 0..9.
// - Simultaneous events, same cycle in COLLECT:
//   - Coin accept and timeout: the coin is added first, then success is evaluated on the new total.
//   - cancel and a coin reaching paid >= cost: success wins.
//   - cancel and timeout: cancel wins; timed_out = 0.
// - rst mid-session: immediate return to IDLE.
//   - All outputs clear and no done pulse is emitted.
//   - Coin value is not retained; the machine refunds nothing.
// TESTING (TICK_CYC=10, TIMEOUT_S=3, DEBOUNCE_CYC=4)
// - Exact pay: start with cost=6; coin 10 for 6 cycles, 00 for 6, then 01 for 6.
//   -> paid 5 then 6; done 2 cycles after paid=6; success=1; chg_one=0, chg_ten=0.
// - Overpay: start with cost=3; one 11 coin.
//   -> paid_ten=1, paid_one=0; success=1; chg_one=7, chg_ten=0.
// - Timeout: start with cost=9; one 10 coin, then idle.
//   -> secs_left steps 3,2,1,0 every 10 cycles; timed_out=1, success=0; chg_one=5 (refund).
// - Debounce: coin toggles 01/00 every 2 cycles, then 01 is held for 40 cycles.
//   -> paid stays 0 during toggling, then increments to exactly 1 (held switch counts once).
// - Collisions:
//   - cancel in the same cycle a coin makes paid >= cost -> success=1.
//   - cancel at the timeout cycle -> timed_out=0, refund = paid.
// - Reset: assert rst mid-COLLECT with paid=5.
//   -> busy=0, paid=0, no done pulse; the next start is accepted normally.

Source files
------------

// File: rtl/pay_collector_if.sv
// pay_collector_if: session control inputs and
// payment/display outputs of the payment stage.
interface pay_collector_if;
  logic       start;
  logic [6:0] cost;
  logic [1:0] coin;
  logic       cancel;
  logic       busy;
  logic [6:0] paid;
  logic [3:0] paid_one;
  logic [3:0] paid_ten;
  logic [3:0] chg_one;
  logic [3:0] chg_ten;
  logic [4:0] secs_left;
  logic       done;
  logic       success;
  logic       timed_out;

  modport master (
    output start, cost, coin, cancel,
    input  busy, paid, paid_one, paid_ten,
    input  chg_one, chg_ten, secs_left,
    input  done, success, timed_out
  );

  modport slave (
    input  start, cost, coin, cancel,
    output busy, paid, paid_one, paid_ten,
    output chg_one, chg_ten, secs_left,
    output done, success, timed_out
  );
endinterface

// File: rtl/pay_collector.sv
// pay_collector: coin debounce, payment accumulation,
// countdown and settle/refund for one vending session.
module pay_collector #(
  parameter int TICK_CYC     = 100_000_000,
  parameter int TIMEOUT_S    = 30,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  pay_collector_if.slave bus
);
  localparam int TW = $clog2(TICK_CYC + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC - 1);
  localparam logic [4:0] SECS_INIT = 5'(TIMEOUT_S);

  typedef enum logic [1:0] {
    IDLE, COLLECT, SETTLE, FINISH
  } state_t;

  state_t state, state_nx;

  logic [6:0]    cost_q, paid_q, chg_q;
  logic [4:0]    secs_q;
  logic [TW-1:0] tick_q;
  logic [DW-1:0] deb_q;
  logic [1:0]    coin_q;
  logic          armed_q, by_to_q;
  logic          success_q, to_q;

  logic       stable, accept;
  logic       tick_wrap, expire, exit_c;
  logic [6:0] coin_val;
  logic [7:0] paid_sum;

  function automatic logic [3:0] tens(logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones(logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  // Coin acceptance, countdown expiry and session exit conditions
  always_comb begin
    stable    = (bus.coin == coin_q) && (deb_q == DEB_MAX);
    accept    = stable && armed_q && (coin_q != 2'b00)
                && (state == COLLECT);
    coin_val  = 7'd0;
    unique case (coin_q)
      2'b01:   coin_val = 7'd1;
      2'b10:   coin_val = 7'd5;
      2'b11:   coin_val = 7'd10;
      default: coin_val = 7'd0;
    endcase
    paid_sum  = {1'b0, paid_q} + {1'b0, coin_val};
    tick_wrap = (state == COLLECT) && (tick_q == TICK_MAX);
    expire    = tick_wrap && (secs_q == 5'd1);
    exit_c    = (paid_q >= cost_q) || bus.cancel || expire;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = COLLECT;
      COLLECT: if (exit_c) state_nx = SETTLE;
      SETTLE:  state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Debounce: a stable nonzero level is taken once; 00 re-arms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_q  <= 2'b00;
      deb_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      if (bus.coin != coin_q) begin
        coin_q <= bus.coin;
        deb_q  <= '0;
      end else if (deb_q != DEB_MAX) begin
        deb_q <= deb_q + 1'b1;
      end
      if (stable && coin_q == 2'b00) armed_q <= 1'b1;
      if (stable && coin_q != 2'b00) armed_q <= 1'b0;
    end
  end

  // Session datapath: arm, accumulate, count down, settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cost_q    <= '0;
      paid_q    <= '0;
      chg_q     <= '0;
      secs_q    <= '0;
      tick_q    <= '0;
      by_to_q   <= 1'b0;
      success_q <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          cost_q    <= bus.cost;
          paid_q    <= '0;
          chg_q     <= '0;
          success_q <= 1'b0;
          to_q      <= 1'b0;
          secs_q    <= SECS_INIT;
          tick_q    <= '0;
          by_to_q   <= 1'b0;
        end
        COLLECT: begin
          if (accept)
            paid_q <= (paid_sum > 8'd99) ? 7'd99 : paid_sum[6:0];
          if (tick_wrap) begin
            tick_q <= '0;
            secs_q <= secs_q - 5'd1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
          by_to_q <= expire && !bus.cancel;
        end
        SETTLE: begin
          if (paid_q >= cost_q) begin
            chg_q     <= paid_q - cost_q;
            success_q <= 1'b1;
          end else begin
            chg_q <= paid_q;
            to_q  <= by_to_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == COLLECT) || (state == SETTLE);
  assign bus.done      = (state == FINISH);
  assign bus.paid      = paid_q;
  assign bus.paid_one  = ones(paid_q);
  assign bus.paid_ten  = tens(paid_q);
  assign bus.chg_one   = ones(chg_q);
  assign bus.chg_ten   = tens(chg_q);
  assign bus.secs_left = secs_q;
  assign bus.success   = success_q;
  assign bus.timed_out = to_q;
endmodule
